// File: rtl/fb_fetch.sv
// fb_fetch -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the word-addressed fetch PC, drives a single-outstanding req/ack
// instruction-memory port and buffers up to two fetched instructions.
// The head entry (pc, pc+1, instruction, branch predecode) is presented
// to IF/ID. Redirects flush the buffer and, if a request is still in
// flight, the stale response is dropped in the DROP state.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lock               IF/ID holding; head entry is not consumed
//   redirect_valid/pc  single-cycle control-flow redirect and target
//   imem_req/addr      fetch request and word address (stable until ack)
//   imem_ack/rdata     request completion and returned instruction
//   if_valid           head entry valid (IF/ID write enable)
//   if_pc/pc_add_1     head PC and head PC + 1
//   if_inst            head instruction
//   if_bra_control     head predecode {funct3, branch, jalr, jal}
module fb_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lock,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_add_1,
   output logic [31:0] if_inst,
   output logic [5:0]  if_bra_control
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   // Branch predecode: {funct3 if BRANCH else 0, BRANCH, JALR, JAL}
   function automatic logic [5:0] predecode(input logic [31:0] inst);
      logic is_jal;
      logic is_jalr;
      logic is_br;
      logic [2:0] f3;
      is_jal  = (inst[6:0] == 7'b1101111);
      is_jalr = (inst[6:0] == 7'b1100111);
      is_br   = (inst[6:0] == 7'b1100011);
      f3      = is_br ? inst[14:12] : 3'b000;
      return {f3, is_br, is_jalr, is_jal};
   endfunction

   state_t      state_r, state_s;
   logic [1:0]  count_r, count_s;
   logic [31:0] fetch_pc_r, fetch_pc_s;
   logic [31:0] addr_r, addr_s;
   logic        req_r, req_s;

   logic        ack_s;
   logic        push_s;
   logic        pop_s;

   logic [31:0] head_pc_r, head_pc1_r, head_inst_r;
   logic [5:0]  head_bra_r;
   logic [31:0] tail_pc_r, tail_pc1_r, tail_inst_r;
   logic [5:0]  tail_bra_r;

   logic [31:0] new_pc_s, new_pc1_s;
   logic [5:0]  new_bra_s;

   // Handshake qualifiers and the entry that an accepted ack would push
   always_comb begin
      ack_s     = imem_ack & req_r;
      push_s    = ack_s & (state_r == ST_RUN) & ~redirect_valid;
      pop_s     = (count_r != 2'd0) & ~lock & ~redirect_valid;
      // In RUN the outstanding address is the fetch PC being pushed
      new_pc_s  = addr_r;
      new_pc1_s = addr_r + 32'd1;
      new_bra_s = predecode(imem_rdata);
   end

   // Next-state logic: fetch FSM, queue occupancy, fetch PC and request
   always_comb begin
      state_s    = state_r;
      count_s    = count_r;
      fetch_pc_s = fetch_pc_r;
      addr_s     = addr_r;
      req_s      = req_r;
      if (redirect_valid) begin
         count_s    = 2'd0;
         fetch_pc_s = redirect_pc;
         if (req_r && !imem_ack) begin
            // In-flight request is now stale: keep it on the bus and drop its data
            state_s = ST_DROP;
            req_s   = 1'b1;
            addr_s  = addr_r;
         end else begin
            state_s = ST_RUN;
            req_s   = 1'b1;
            addr_s  = redirect_pc;
         end
      end else begin
         case (state_r)
            ST_RUN: begin
               count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
               if (push_s) begin
                  fetch_pc_s = fetch_pc_r + 32'd1;
               end else begin
                  fetch_pc_s = fetch_pc_r;
               end
               if (req_r && !imem_ack) begin
                  req_s  = 1'b1;
                  addr_s = addr_r;
               end else begin
                  // Only raise a request that is guaranteed a queue slot
                  req_s  = (count_s < 2'd2);
                  addr_s = fetch_pc_s;
               end
            end
            ST_DROP: begin
               if (ack_s) begin
                  state_s = ST_RUN;
                  req_s   = 1'b1;
                  addr_s  = fetch_pc_r;
               end else begin
                  state_s = ST_DROP;
                  req_s   = 1'b1;
                  addr_s  = addr_r;
               end
            end
            default: begin
               state_s = ST_RUN;
               count_s = 2'd0;
               req_s   = 1'b0;
            end
         endcase
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_RUN;
         count_r    <= 2'd0;
         fetch_pc_r <= RESET_PC;
         addr_r     <= RESET_PC;
         req_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         count_r    <= count_s;
         fetch_pc_r <= fetch_pc_s;
         addr_r     <= addr_s;
         req_r      <= req_s;
      end
   end

   // Two-entry queue storage; head holds its value when the queue empties
   always_ff @(posedge clk) begin
      if (rst) begin
         head_pc_r   <= 32'd0;
         head_pc1_r  <= 32'd0;
         head_inst_r <= 32'd0;
         head_bra_r  <= 6'd0;
         tail_pc_r   <= 32'd0;
         tail_pc1_r  <= 32'd0;
         tail_inst_r <= 32'd0;
         tail_bra_r  <= 6'd0;
      end else if (push_s) begin
         case (count_r)
            2'd0: begin
               head_pc_r   <= new_pc_s;
               head_pc1_r  <= new_pc1_s;
               head_inst_r <= imem_rdata;
               head_bra_r  <= new_bra_s;
            end
            2'd1: begin
               if (pop_s) begin
                  head_pc_r   <= new_pc_s;
                  head_pc1_r  <= new_pc1_s;
                  head_inst_r <= imem_rdata;
                  head_bra_r  <= new_bra_s;
               end else begin
                  tail_pc_r   <= new_pc_s;
                  tail_pc1_r  <= new_pc1_s;
                  tail_inst_r <= imem_rdata;
                  tail_bra_r  <= new_bra_s;
               end
            end
            default: begin
               // Full queue only accepts a push alongside a pop
               head_pc_r   <= tail_pc_r;
               head_pc1_r  <= tail_pc1_r;
               head_inst_r <= tail_inst_r;
               head_bra_r  <= tail_bra_r;
               tail_pc_r   <= new_pc_s;
               tail_pc1_r  <= new_pc1_s;
               tail_inst_r <= imem_rdata;
               tail_bra_r  <= new_bra_s;
            end
         endcase
      end else if (pop_s && (count_r == 2'd2)) begin
         head_pc_r   <= tail_pc_r;
         head_pc1_r  <= tail_pc1_r;
         head_inst_r <= tail_inst_r;
         head_bra_r  <= tail_bra_r;
      end
   end

   assign imem_req       = req_r;
   assign imem_addr      = addr_r;
   assign if_valid       = (count_r != 2'd0);
   assign if_pc          = head_pc_r;
   assign if_pc_add_1    = head_pc1_r;
   assign if_inst        = head_inst_r;
   assign if_bra_control = head_bra_r;

endmodule

// File: doc/fb_fetch.md
# fb_fetch

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the word-addressed fetch PC and drives a req/ack instruction-memory port. It buffers up to two fetched instructions in a small queue and presents the head entry (pc, pc+1, instruction, branch predecode) to IF/ID. It honours the hazard unit's `lock` and the execute stage's branch/jump redirect, including discarding an in-flight fetch made stale by a redirect.

## Interface
- `RESET_PC`, default `32'h0`: fetch address after reset (word address).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `lock` in 1: IF/ID holding (data hazard); head entry must not be consumed.
- `redirect_valid` in 1: single-cycle pulse, control-flow redirect / misprediction.
- `redirect_pc` in 32: new fetch word address, sampled when `redirect_valid`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address for the request.
- `imem_ack` in 1: memory completes the request this cycle.
- `imem_rdata` in 32: instruction, valid in the cycle `imem_ack`=1.
- `if_valid` out 1: head entry valid; drives IF/ID `we`.
- `if_pc` out 32: head PC.
- `if_pc_add_1` out 32: head PC + 1, mod 2^32.
- `if_inst` out 32: head instruction.
- `if_bra_control` out 6: head branch predecode.

## Operation
- Memory protocol:
  - Once `imem_req` rises, `imem_req` and `imem_addr` stay stable until the cycle with `imem_ack`=1.
  - Ack may arrive in the same cycle as the request (zero wait) or any number of cycles later.
  - At most one request is outstanding.
- Queue: two entries, `count` ranges 0..2.
  - Push: on an accepted ack (RUN state, no redirect this cycle).
  - Pop: at a clock edge with `count>0` and `lock==0`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push never overflows, because a request is only raised when `count<2`.
- Request rule: a new request is raised in RUN when `count<2`. After an ack, the next request may be raised the following cycle.
- Fetch PC: `imem_addr` = fetch_pc. On an accepted ack, fetch_pc <= fetch_pc+1, wrapping `32'hFFFFFFFF`→0.
- Outputs:
  - `if_valid` = (`count>0`).
  - `if_pc`, `if_pc_add_1`, `if_inst`, `if_bra_control` come from the head entry. They hold their last values when the queue is empty.
- Predecode (computed at push from `imem_rdata[6:0]`):
  - bit0 = opcode 1101111 (JAL).
  - bit1 = opcode 1100111 (JALR).
  - bit2 = opcode 1100011 (BRANCH).
  - bits5:3 = funct3 (`[14:12]`) if BRANCH, else 0.
- States: RUN and DROP.
  - RUN: normal fetching.
  - DROP: a stale request is outstanding. `imem_req` stays high with the old address. On `imem_ack` the data is discarded and the state goes to RUN; the next request, using the redirect target, is raised the following cycle.
- Redirect (processed regardless of `lock`):
  - Queue flushed (`count<=0`); fetch_pc <= `redirect_pc`.
  - If RUN with a request outstanding and no ack this cycle: go to DROP.
  - If ack arrives in the same cycle as the redirect: discard data, stay in RUN.
  - Redirect while in DROP: update fetch_pc, remain in DROP.
  - Redirect with no request outstanding: stay in RUN.

## Timing
- Reset: fetch_pc=`RESET_PC`, state RUN, `count`=0, `imem_req`=0 during the reset cycle. All head outputs are 0 and `if_valid`=0.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency: ack in cycle N → `if_valid`=1 with that instruction in cycle N+1 (queue was empty).
- Throughput: one instruction per cycle with zero-wait memory and `lock`=0.
- A redirect pulsed in cycle N drops `if_valid` to 0 in cycle N+1. The earliest target fetch is:
  - cycle N+1 if no stale request was outstanding;
  - the cycle after the stale ack otherwise.
- Reset mid-request: the request is abandoned and the ack is ignored. The memory is also reset by the same `rst`.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait memory, `lock`=0 → `if_pc` 0x100, 0x101, 0x102 on consecutive cycles; `if_pc_add_1` = pc+1.
- Hold `lock`=1 for 5 cycles after the first instruction arrives → `count` reaches 2, `imem_req` drops, `if_pc` stays 0x100. After release, 0x101 follows the next cycle with no loss or duplication.
- Memory with 3 wait states; redirect to 0x40 one cycle after the request to 0x5 → stale ack discarded, next `imem_addr`=0x40, first valid `if_pc`=0x40.
- Redirect in the same cycle as an ack → that instruction never appears and `if_valid`=0 the next cycle.
- Fetch `imem_rdata`=0x00208463 (BEQ) → `if_bra_control`=6'b000100. 0x0000006F (JAL) → 6'b000001.
- fetch_pc = 0xFFFFFFFF → `if_pc_add_1`=0, next `if_pc`=0.
